// File: rtl/audio_level_meter_pkg.sv
// Shared types for the LED frame path: arbiter FSM states, requester encodings
// and the round-robin grant rule.
package audio_level_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2
    } arb_state_t;

    localparam logic SRC_METER   = 1'b0;
    localparam logic SRC_OVERLAY = 1'b1;

    // A lone eligible requester wins; on a tie the one not served last wins.
    function automatic logic pick_grant(input logic [1:0] eligible, input logic last_grant);
        if (eligible == 2'b11) begin
            return ~last_grant;
        end
        return eligible[1] ? SRC_OVERLAY : SRC_METER;
    endfunction

endpackage

// File: rtl/frame_interval_timer.sv
// Loadable down-counter that enforces the minimum spacing between frame
// captures; expired while the count is zero.
module frame_interval_timer #(
    parameter int frame_interval = 441
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int tw = (frame_interval < 2) ? 1 : $clog2(frame_interval + 1);
    localparam logic [tw-1:0] load_value = tw'(frame_interval - 1);

    logic [tw-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - tw'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/led_frame_arbiter.sv
// Shares the STP16CPC26 driver chain between the meter and overlay frame
// sources, rate-limiting frame captures with frame_interval_timer.
module led_frame_arbiter
    import audio_level_meter_pkg::*;
#(
    parameter int width          = 64,
    parameter int frame_interval = 441
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_valid,
    output logic [1:0]       i_ready,
    input  logic [width-1:0] i_data0,
    input  logic [width-1:0] i_data1,
    input  logic             override,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_data,
    output logic             o_source,
    output logic [1:0]       fsm_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid is held with stable data until then, and ready/valid driven
    // here depend only on registered state.
    arb_state_t       state, state_next;
    logic             grant, grant_next;
    logic             last_grant;
    logic             capture;
    logic             expired;
    logic [1:0]       eligible;
    logic [width-1:0] frame_q;
    logic             source_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= SRC_METER;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        capture    = 1'b0;
        eligible   = i_valid & (override ? 2'b10 : 2'b11);
        case (state)
            IDLE: begin
                if ((eligible != 2'b00) && expired) begin
                    grant_next = pick_grant(eligible, last_grant);
                    state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                if (i_valid[grant]) begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (o_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q    <= '0;
            source_q   <= SRC_METER;
            last_grant <= SRC_OVERLAY;
        end else if (capture) begin
            frame_q    <= grant ? i_data1 : i_data0;
            source_q   <= grant;
            last_grant <= grant;
        end
    end

    frame_interval_timer #(
        .frame_interval(frame_interval)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (capture),
        .expired(expired)
    );

    assign i_ready   = (state == ACCEPT) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign o_valid   = (state == SEND);
    assign o_data    = frame_q;
    assign o_source  = source_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed and randomized checks of led_frame_arbiter against a transaction
// model built from the arbitration, capture and spacing rules.
module tb_led_frame_arbiter;

    localparam int W  = 64;
    localparam int FI = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   i_valid;
    logic [1:0]   i_ready;
    logic [W-1:0] i_data0, i_data1, o_data;
    logic         override, o_valid, o_ready, o_source;
    logic [1:0]   fsm_state;

    always #5 clk = ~clk;

    led_frame_arbiter #(.width(W), .frame_interval(FI)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data0  (i_data0),
        .i_data1  (i_data1),
        .override (override),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_source (o_source),
        .fsm_state(fsm_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: 0 = free to arbitrate, 1 = granted, 2 = holding a frame.
    int           m_phase, m_free_from, m_cap_cycle;
    logic         m_g, m_last, m_src;
    logic [W-1:0] m_data;
    logic [1:0]   acc;
    logic [W-1:0] exp_q[$];
    logic         src_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_phase = 0; m_free_from = 0; m_cap_cycle = 0;
        m_g = 1'b0; m_last = 1'b1; m_src = 1'b0; m_data = '0; acc = 2'b00;
        exp_q.delete(); src_q.delete();
    endtask

    task automatic tick();
        logic [1:0] elig;
        check("i_ready", i_ready, (m_phase == 1) ? (m_g ? 2'b10 : 2'b01) : 2'b00);
        check("o_valid", o_valid, m_phase == 2);
        if (m_phase == 2) begin
            check("o_data", o_data, m_data);
            check("o_source", o_source, m_src);
        end
        if (o_valid && o_ready) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else check("sb_data", o_data, exp_q.pop_front());
        end
        acc = 2'b00;
        case (m_phase)
            0: if (cyc >= m_free_from) begin
                elig = i_valid & (override ? 2'b10 : 2'b11);
                if (elig != 2'b00) begin
                    m_g = (elig == 2'b11) ? ~m_last : elig[1];
                    m_phase = 1;
                end
            end
            1: if (i_valid[m_g]) begin
                m_data = m_g ? i_data1 : i_data0;
                m_src = m_g; m_last = m_g; m_cap_cycle = cyc;
                exp_q.push_back(m_data); src_q.push_back(m_g);
                acc[m_g] = 1'b1;
                m_phase = 2;
            end
            default: if (o_ready) begin
                m_phase = 0;
                m_free_from = (cyc + 1 > m_cap_cycle + FI) ? cyc + 1 : m_cap_cycle + FI;
            end
        endcase
        @(posedge clk); #1;
        cyc++;
    endtask

    // mode 0: drop accepted requests; 1: keep requests up; 2: random traffic.
    task automatic drive(input int mode);
        for (int r = 0; r < 2; r++) begin
            if (mode != 1 && acc[r]) i_valid[r] = 1'b0;
            if (mode == 2 && !i_valid[r] && $urandom_range(0, 2) == 0) begin
                i_valid[r] = 1'b1;
                if (r == 0) i_data0 = {$urandom, $urandom};
                else        i_data1 = {$urandom, $urandom};
            end
        end
        if (mode == 2) begin
            o_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) override = ~override;
        end
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin
            tick();
            drive(mode);
        end
    endtask

    task automatic run_until(input int ph, input int mode, input string tag);
        int k = 0;
        while (m_phase != ph && k < 50) begin
            tick();
            drive(mode);
            k++;
        end
        check(tag, (m_phase == ph), 1);
    endtask

    task automatic apply_reset();
        reset = 1'b1; i_valid = 2'b00; o_ready = 1'b1; override = 1'b0;
        i_data0 = '0; i_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_ready", i_ready, 2'b00);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_source", o_source, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_o_valid"}, o_valid, 0);
        check({tag, "_i_ready"}, i_ready, 2'b00);
        check({tag, "_o_data"}, o_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_rr[4];
        int   n_meter;
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Single source at minimum latency, then a second frame held off by the timer.
        apply_reset();
        i_valid = 2'b01; i_data0 = 64'hA5;
        run(3, 0);
        i_valid = 2'b01; i_data0 = 64'h5A;
        run(8, 0);

        // Round-robin with both requesters always valid.
        apply_reset();
        i_valid = 2'b11; i_data0 = 64'h1; i_data1 = 64'h2;
        run(25, 1);
        check("rr_count", (src_q.size() >= 4), 1);
        for (int i = 0; i < 4; i++)
            if (i < src_q.size()) check($sformatf("rr_src%0d", i), src_q[i], exp_rr[i]);

        // Override: only requester 1 served; releasing it hands the tie to 0.
        run_until(2, 1, "ovr_reach_send");
        override = 1'b1;
        src_q.delete();
        run(25, 1);
        n_meter = 0;
        foreach (src_q[i]) if (src_q[i] == 1'b0) n_meter++;
        check("ovr_any", (src_q.size() >= 3), 1);
        check("ovr_meter_grants", n_meter, 0);
        run_until(2, 1, "ovr_rel_send");
        override = 1'b0;
        src_q.delete();
        run(12, 1);
        check("ovr_rel_count", (src_q.size() >= 1), 1);
        if (src_q.size() >= 1) check("ovr_rel_src", src_q[0], 0);

        // Backpressure: held frame stable for 20 cycles, then a pending grant follows.
        apply_reset();
        o_ready = 1'b0;
        i_valid = 2'b01; i_data0 = 64'hDEAD_BEEF_0123_4567;
        run_until(2, 0, "bp_reach_send");
        i_valid = 2'b10; i_data1 = 64'h0F0F_0000_FFFF_1234;
        run(20, 0);
        check("bp_stable", o_data, 64'hDEAD_BEEF_0123_4567);
        o_ready = 1'b1;
        run(8, 0);

        // Override raised while a meter frame is in SEND.
        apply_reset();
        i_valid = 2'b01; i_data0 = 64'h1111;
        run_until(2, 0, "os_reach_send");
        override = 1'b1;
        i_valid = 2'b11; i_data0 = 64'h2222; i_data1 = 64'h3333;
        src_q.delete();
        run(12, 0);
        check("os_count", (src_q.size() >= 1), 1);
        if (src_q.size() >= 1) check("os_next_src", src_q[0], 1);

        // Asynchronous reset during ACCEPT and during SEND.
        apply_reset();
        i_valid = 2'b11; i_data0 = 64'hAAAA; i_data1 = 64'hBBBB;
        run(6, 1);
        run_until(1, 1, "ar_reach_accept");
        async_reset_pulse("ar_acc");
        run(4, 1);
        check("ar_acc_count", (src_q.size() >= 1), 1);
        if (src_q.size() >= 1) check("ar_acc_first", src_q[0], 0);
        run(6, 1);
        run_until(2, 1, "ar_reach_send");
        async_reset_pulse("ar_send");
        run(4, 1);
        check("ar_send_count", (src_q.size() >= 1), 1);
        if (src_q.size() >= 1) check("ar_send_first", src_q[0], 0);

        // Randomized traffic, backpressure and override toggling.
        apply_reset();
        run(500, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
